mc_mem: RTL and testbench
=========================

MC_MEM -- requirements
Module: mc_mem

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter MEM_BYTES, default 1024, implemented storage in bytes; SHALL be a multiple of DATA_W/8.
REQ-004 Parameter LATENCY, default 2, accept-to-response cycles; legal range 1..15.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request this cycle.
REQ-009 req_wr  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  byte address of the word's MSB byte.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte enables; bit DATA_W/8-1 selects the byte at req_addr (MSB).
REQ-013 resp_valid  out  1  one-cycle response strobe.
REQ-014 resp_rdata  out  DATA_W  read data, big-endian.
REQ-015 resp_err  out  1  request was faulted; qualified by resp_valid.
REQ-016 busy  out  1  a request is in flight (state not IDLE).

Function
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid & req_ready.
REQ-019 On accept, wr, addr, wdata and be SHALL be latched; later changes on req_* have no effect.
REQ-020 IDLE->WAIT on accept with LATENCY>1; IDLE->RESP on accept with LATENCY=1.
REQ-021 WAIT: a 4-bit counter loads LATENCY-2 on accept and decrements; at 0, WAIT->RESP.
REQ-022 RESP lasts exactly one cycle with resp_valid=1, then ->IDLE; the earliest next accept is one cycle after the resp_valid cycle.
REQ-023 An accept in cycle T SHALL produce resp_valid in cycle T+LATENCY.
REQ-024 Fault if the low log2(DATA_W/8) address bits are nonzero (misaligned) or addr+DATA_W/8 > MEM_BYTES (out of range).
REQ-025 Faulted request: resp_err=1, resp_rdata=0, no storage modified, same latency as a good request.
REQ-026 Good read: resp_rdata = {mem[addr], mem[addr+1], ...}, sampled on the transition into RESP; resp_err=0.
REQ-027 Good write: on the transition into RESP, each byte i whose be bit is 1 is written; resp_rdata=0, resp_err=0; be=0 is a legal no-op write.
REQ-028 A read following a write to the same address SHALL return the written data.
REQ-029 resp_rdata and resp_err SHALL hold their values outside RESP until the next response (registered outputs).
REQ-030 busy = (state != IDLE).

Reset
REQ-031 rst SHALL force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, req_ready 1 on the next edge.
REQ-032 rst SHALL NOT clear storage contents.
REQ-033 rst during WAIT or RESP aborts the request: no resp_valid, and a pending write SHALL NOT commit.
REQ-034 rst overrides a simultaneous req_valid; no request is accepted in a reset cycle.

Verification
REQ-035 LATENCY=2: write addr 0x0010, wdata 0xBEEF, be 11, accepted T -> resp_valid at T+2, err 0; read 0x0010 -> rdata 0xBEEF, mem[0x10]=0xBE.
REQ-036 be=01 write 0x1234 to 0x0010 holding 0xBEEF -> later read returns 0xBE34.
REQ-037 Read addr 0x0011 (misaligned) and addr 0x0400 with MEM_BYTES=1024 -> resp_err=1, rdata 0x0000, contents unchanged.
REQ-038 req_valid held high continuously -> req_ready toggles, accepts every LATENCY+1 cycles, busy high in WAIT/RESP.
REQ-039 rst asserted one cycle after accepting a write of 0xAAAA to 0x0020 -> no resp_valid, read 0x0020 returns the prior value.
REQ-040 LATENCY=1, DATA_W=32: write 0xDEADBEEF to 0x0004 -> resp_valid at T+1; read returns 0xDEADBEEF.

Source files
------------

// File: rtl/mc_mem.sv
// mc_mem: byte-addressed, big-endian word memory behind a single-outstanding
// valid/ready request port with a fixed accept-to-response latency.
//   state | meaning
//   IDLE  | ready for a request (req_ready=1)
//   WAIT  | request latched, latency counter running
//   RESP  | one-cycle response strobe, then back to IDLE
module mc_mem #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int MW    = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              accept, go_resp;
  logic              l_wr;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [NB-1:0]     l_be;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [NB-1:0]     cur_be;
  logic [32:0]       end_addr;
  logic              fault;
  logic [MW-1:0]     base;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        mem [MEM_BYTES];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            go_resp   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          go_resp   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_wr    <= req_wr;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_be    <= req_be;
    end
  end

  // With LATENCY=1 the response is formed in the accept cycle, before the
  // request registers have loaded, so IDLE uses the live request inputs.
  always_comb begin
    cur_wr    = (state == IDLE) ? req_wr    : l_wr;
    cur_addr  = (state == IDLE) ? req_addr  : l_addr;
    cur_wdata = (state == IDLE) ? req_wdata : l_wdata;
    cur_be    = (state == IDLE) ? req_be    : l_be;
  end

  assign end_addr = 33'(cur_addr) + 33'(NB);
  assign fault    = (|cur_addr[OFF_W-1:0]) || (end_addr > 33'(MEM_BYTES));
  assign base     = MW'(cur_addr);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) begin
      rd_word[DATA_W-1-8*i -: 8] = mem[base + MW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= go_resp;
      if (go_resp) begin
        resp_err   <= fault;
        resp_rdata <= (fault || cur_wr) ? '0 : rd_word;
      end
    end
  end

  // Storage has no reset; a reset cycle suppresses any commit.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_wr && !fault) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[NB-1-i]) mem[base + MW'(i)] <= cur_wdata[DATA_W-1-8*i -: 8];
      end
    end
  end

endmodule

// File: tb/tb_mc_mem.sv
// Scoreboard bench for mc_mem: a 16-bit/LATENCY=2 instance (a) and a
// 32-bit/LATENCY=1 instance (b) checked against a byte-array reference model.
module tb_mc_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_valid, a_ready, a_wr, a_rv, a_err, a_busy;
  logic [15:0] a_addr, a_wdata, a_rd;
  logic [1:0]  a_be;
  logic        b_valid, b_ready, b_wr, b_rv, b_err, b_busy;
  logic [15:0] b_addr;
  logic [31:0] b_wdata, b_rd;
  logic [3:0]  b_be;

  mc_mem #(.DATA_W(16), .ADDR_W(16), .MEM_BYTES(1024), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .resp_valid(a_rv),
    .resp_rdata(a_rd), .resp_err(a_err), .busy(a_busy));

  mc_mem #(.DATA_W(32), .ADDR_W(16), .MEM_BYTES(1024), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .resp_valid(b_rv),
    .resp_rdata(b_rd), .resp_err(b_err), .busy(b_busy));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t       q_a[$], q_b[$];
  logic [7:0] ref_a [1024];
  logic [7:0] ref_b [1024];

  function automatic exp_t predict(input bit wide, input logic wr, input logic [15:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int nb  = wide ? 4 : 2;
    int lat = wide ? 1 : 2;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be;
    e.cyc   = cyc + lat;
    e.err   = ((int'(addr) % nb) != 0) || (int'(addr) + nb > 1024);
    e.rdata = 32'h0;
    if (!e.err && !wr)
      for (int i = 0; i < nb; i++)
        e.rdata = (e.rdata << 8) | 32'(wide ? ref_b[int'(addr) + i] : ref_a[int'(addr) + i]);
    return e;
  endfunction

  task automatic commit(input bit wide, input exp_t e);
    int nb = wide ? 4 : 2;
    if (e.wr && !e.err)
      for (int i = 0; i < nb; i++)
        if (e.be[nb-1-i]) begin
          if (wide) ref_b[int'(e.addr) + i] = e.wdata[8*(nb-1-i) +: 8];
          else      ref_a[int'(e.addr) + i] = e.wdata[8*(nb-1-i) +: 8];
        end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A reset aborts anything in flight, so its expectations are dropped too.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (a_rv) begin
        if (q_a.size() == 0) check("a_unexpected_resp", 32'(a_rv), 32'h0);
        else begin
          e = q_a.pop_front();
          check("a_latency", cyc, e.cyc);
          check("a_err", 32'(a_err), 32'(e.err));
          check("a_rdata", 32'(a_rd), e.rdata);
          commit(1'b0, e);
        end
      end
      if (b_rv) begin
        if (q_b.size() == 0) check("b_unexpected_resp", 32'(b_rv), 32'h0);
        else begin
          e = q_b.pop_front();
          check("b_latency", cyc, e.cyc);
          check("b_err", 32'(b_err), 32'(e.err));
          check("b_rdata", b_rd, e.rdata);
          commit(1'b1, e);
        end
      end
      if (a_valid && a_ready) q_a.push_back(predict(1'b0, a_wr, a_addr, 32'(a_wdata), {2'b00, a_be}));
      if (b_valid && b_ready) q_b.push_back(predict(1'b1, b_wr, b_addr, b_wdata, b_be));
    end
  end

  task automatic req(input bit wide, input logic wr, input logic [15:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    int k;
    @(posedge clk); #1;
    if (wide) begin b_valid = 1; b_wr = wr; b_addr = addr; b_wdata = wdata; b_be = be; end
    else begin a_valid = 1; a_wr = wr; a_addr = addr; a_wdata = wdata[15:0]; a_be = be[1:0]; end
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wide ? b_ready : a_ready) break;
    end
    if (k == 40) check("accept_timeout", 32'(wide ? b_ready : a_ready), 32'h1);
    @(posedge clk); #1;
    // Disturb the request inputs after accept; the DUT must use its latched copy.
    if (wide) begin b_valid = 0; b_wr = ~wr; b_addr = addr ^ 16'h0013; b_wdata = ~wdata; b_be = ~be; end
    else begin a_valid = 0; a_wr = ~wr; a_addr = addr ^ 16'h0013; a_wdata = ~wdata[15:0]; a_be = ~be[1:0]; end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!a_busy && !b_busy && q_a.size() == 0 && q_b.size() == 0) break;
    end
    if (k == 40) check("idle_timeout", 32'(q_a.size() + q_b.size()) + {30'b0, a_busy, b_busy}, 32'h0);
  endtask

  initial begin
    rst = 1;
    a_valid = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_valid = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    repeat (2) @(posedge clk);
    #1 a_valid = 1; b_valid = 1;
    @(negedge clk);
    check("rst_ready", 32'(a_ready), 32'h1);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_resp_valid", 32'(a_rv), 32'h0);
    check("rst_rdata", 32'(a_rd), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_b_ready", 32'(b_ready), 32'h1);
    @(posedge clk); #1 rst = 0; a_valid = 0; b_valid = 0;
    @(negedge clk);
    check("rst_no_accept_a", 32'(a_busy), 32'h0);
    check("rst_no_accept_b", 32'(b_busy), 32'h0);

    req(0, 1, 16'h0000, 32'h5A5A, 4'h3); wait_idle();
    req(0, 1, 16'h0010, 32'hBEEF, 4'h3); wait_idle();
    req(0, 0, 16'h0010, 32'h0000, 4'h0); wait_idle();
    req(0, 1, 16'h0010, 32'h1234, 4'h1); wait_idle();
    req(0, 0, 16'h0010, 32'h0000, 4'h3); wait_idle();
    req(0, 1, 16'h0010, 32'hFFFF, 4'h0); wait_idle();
    req(0, 0, 16'h0010, 32'h0000, 4'h0); wait_idle();
    req(0, 0, 16'h0011, 32'h0000, 4'h0); wait_idle();
    req(0, 0, 16'h0400, 32'h0000, 4'h0); wait_idle();
    req(0, 1, 16'h0400, 32'h7777, 4'h3); wait_idle();
    req(0, 1, 16'h0011, 32'h7777, 4'h3); wait_idle();
    req(0, 0, 16'h0010, 32'h0000, 4'h0); wait_idle();
    req(0, 1, 16'h03FE, 32'hCAFE, 4'h3); wait_idle();
    req(0, 0, 16'h03FE, 32'h0000, 4'h0); wait_idle();
    req(0, 0, 16'h03FF, 32'h0000, 4'h0); wait_idle();

    // Back-to-back: valid held high, accept every LATENCY+1 = 3 cycles.
    @(posedge clk); #1 a_valid = 1; a_wr = 0; a_addr = 16'h0000; a_be = 2'b11;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", k), 32'(a_ready), 32'((k % 3) == 0));
      check($sformatf("b2b_busy_%0d", k), 32'(a_busy), 32'((k % 3) != 0));
    end
    @(posedge clk); #1 a_valid = 0;
    wait_idle();

    // Reset one cycle after accepting a write: nothing commits, no response.
    req(0, 1, 16'h0020, 32'h1111, 4'h3); wait_idle();
    @(posedge clk); #1 a_valid = 1; a_wr = 1; a_addr = 16'h0020; a_wdata = 16'hAAAA; a_be = 2'b11;
    @(negedge clk);
    check("abort_accept_ready", 32'(a_ready), 32'h1);
    @(posedge clk); #1 a_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("abort_resp_valid", 32'(a_rv), 32'h0);
    check("abort_busy", 32'(a_busy), 32'h0);
    check("abort_ready", 32'(a_ready), 32'h1);
    check("abort_rdata", 32'(a_rd), 32'h0);
    repeat (3) @(negedge clk);
    req(0, 0, 16'h0020, 32'h0000, 4'h0); wait_idle();

    req(1, 1, 16'h0004, 32'hDEADBEEF, 4'hF); wait_idle();
    req(1, 0, 16'h0004, 32'h0, 4'h0); wait_idle();
    req(1, 1, 16'h0004, 32'h11223344, 4'h8); wait_idle();
    req(1, 0, 16'h0004, 32'h0, 4'h0); wait_idle();
    req(1, 0, 16'h0006, 32'h0, 4'h0); wait_idle();
    req(1, 0, 16'h03FE, 32'h0, 4'h0); wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
